// File: rtl/ascon_pack.sv
// Shared state encoding and round-index constants for the ASCON-128 control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascon_pack;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_AD      = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PT      = 3'd5,
    ST_FINAL   = 3'd6,
    ST_DONE    = 3'd7
  } type_fsm_state;

  localparam logic [3:0] ROUND_A_START = 4'd0;
  localparam logic [3:0] ROUND_B_START = 4'd6;
  localparam logic [3:0] LAST_ROUND    = 4'd11;

endpackage

// File: rtl/round_counter.sv
// Loadable 4-bit round index: init_a loads the p^a start, init_b the p^b start, en steps.
// Latency: 1 cycle from load/step to round_o.
// Backpressure: none; holds its value when no control input is active.
module round_counter
  import ascon_pack::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  input  logic       en_i,
  output logic [3:0] round_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      round_o <= ROUND_A_START;
    end else if (init_a_i) begin
      round_o <= ROUND_A_START;
    end else if (init_b_i) begin
      round_o <= ROUND_B_START;
    end else if (en_i) begin
      round_o <= round_o + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_fsm.sv
// ASCON-128 encryption control FSM driving the permutation datapath; ASCON_FSM_ABORT_EN adds abort_i.
// Latency: done_o rises 12 + 7*ad + 7*(pt-1) + 1 + 12 + 1 cycles after start with data always valid.
// Backpressure: waits in WAIT_AD/WAIT_PT with data_req_o high until data_valid_i; rounds freeze meanwhile.
module ascon_fsm
  import ascon_pack::*;
#(
  parameter int AD_CNT_W = 4,
  parameter int PT_CNT_W = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [AD_CNT_W-1:0] ad_blocks_i,
  input  logic [PT_CNT_W-1:0] pt_blocks_i,
  input  logic                data_valid_i,
`ifdef ASCON_FSM_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                data_req_o,
  output logic                select_o,
  output logic [3:0]          round_o,
  output logic                en_state_o,
  output logic                en_xor_data_o,
  output logic                en_xor_key_begin_o,
  output logic                en_xor_key_end_o,
  output logic                en_xor_lsb_o,
  output logic                en_cipher_o,
  output logic                en_tag_o,
  output logic                cipher_valid_o,
  output logic                tag_valid_o,
  output logic                done_o
);

  type_fsm_state       state, state_d;
  logic [AD_CNT_W-1:0] ad_cnt, ad_cnt_d;
  logic [PT_CNT_W-1:0] pt_cnt, pt_cnt_d;
  logic                init_a, init_b, cnt_en, last_round, abort;

`ifdef ASCON_FSM_ABORT_EN
  assign abort = abort_i && (state != ST_IDLE);
`else
  assign abort = 1'b0;
`endif

  assign last_round = (round_o == LAST_ROUND);

  round_counter u_round_counter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .init_a_i (init_a),
    .init_b_i (init_b),
    .en_i     (cnt_en),
    .round_o  (round_o)
  );

  always_comb begin
    state_d  = state;
    ad_cnt_d = ad_cnt;
    pt_cnt_d = pt_cnt;
    init_a   = 1'b0;
    init_b   = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          ad_cnt_d = ad_blocks_i;
          pt_cnt_d = (pt_blocks_i == '0) ? PT_CNT_W'(1) : pt_blocks_i;
          state_d  = ST_INIT;
          init_a   = 1'b1;
        end
      end
      ST_INIT: begin
        if (last_round) state_d = (ad_cnt == '0) ? ST_WAIT_PT : ST_WAIT_AD;
        else            cnt_en  = 1'b1;
      end
      ST_WAIT_AD: begin
        if (data_valid_i) begin
          if (ad_cnt != '0) ad_cnt_d = ad_cnt - AD_CNT_W'(1);
          state_d = ST_AD;
          init_b  = 1'b1;
        end
      end
      ST_AD: begin
        if (last_round) state_d = (ad_cnt == '0) ? ST_WAIT_PT : ST_WAIT_AD;
        else            cnt_en  = 1'b1;
      end
      ST_WAIT_PT: begin
        if (data_valid_i) begin
          if (pt_cnt != '0) pt_cnt_d = pt_cnt - PT_CNT_W'(1);
          // The last plaintext block is absorbed in FINAL round 0, not in a PT pass.
          if (pt_cnt <= PT_CNT_W'(1)) begin
            state_d = ST_FINAL;
            init_a  = 1'b1;
          end else begin
            state_d = ST_PT;
            init_b  = 1'b1;
          end
        end
      end
      ST_PT: begin
        if (last_round) state_d = ST_WAIT_PT;
        else            cnt_en  = 1'b1;
      end
      ST_FINAL: begin
        if (last_round) state_d = ST_DONE;
        else            cnt_en  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      init_a  = 1'b1;
      init_b  = 1'b0;
      cnt_en  = 1'b0;
    end
  end

  always_comb begin
    data_req_o         = 1'b0;
    select_o           = 1'b0;
    en_state_o         = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_key_begin_o = 1'b0;
    en_xor_key_end_o   = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_cipher_o        = 1'b0;
    en_tag_o           = 1'b0;
    tag_valid_o        = 1'b0;
    done_o             = 1'b0;
    case (state)
      ST_INIT: begin
        en_state_o       = 1'b1;
        select_o         = (round_o != ROUND_A_START);
        en_xor_key_end_o = last_round;
        en_xor_lsb_o     = last_round && (ad_cnt == '0);
      end
      ST_WAIT_AD, ST_WAIT_PT: data_req_o = 1'b1;
      ST_AD: begin
        en_state_o    = 1'b1;
        select_o      = 1'b1;
        en_xor_data_o = (round_o == ROUND_B_START);
        en_xor_lsb_o  = last_round && (ad_cnt == '0);
      end
      ST_PT: begin
        en_state_o    = 1'b1;
        select_o      = 1'b1;
        en_xor_data_o = (round_o == ROUND_B_START);
        en_cipher_o   = (round_o == ROUND_B_START);
      end
      ST_FINAL: begin
        en_state_o         = 1'b1;
        select_o           = 1'b1;
        en_xor_data_o      = (round_o == ROUND_A_START);
        en_xor_key_begin_o = (round_o == ROUND_A_START);
        en_cipher_o        = (round_o == ROUND_A_START);
        en_xor_key_end_o   = last_round;
        en_tag_o           = last_round;
      end
      ST_DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      ad_cnt         <= '0;
      pt_cnt         <= '0;
      cipher_valid_o <= 1'b0;
    end else begin
      state          <= state_d;
      ad_cnt         <= ad_cnt_d;
      pt_cnt         <= pt_cnt_d;
      cipher_valid_o <= en_cipher_o && !abort;
    end
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Directed bench for ascon_fsm: per-cycle comparison against a phase-level trace model.
module tb_ascon_fsm;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic [3:0] ad_blocks_i = 4'd0;
  logic [3:0] pt_blocks_i = 4'd0;
`ifdef ASCON_FSM_ABORT_EN
  logic       abort_i = 1'b0;
`endif
  logic       data_req_o, select_o, en_state_o, en_xor_data_o, en_xor_key_begin_o;
  logic       en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o;
  logic       cipher_valid_o, tag_valid_o, done_o;
  logic [3:0] round_o;

  always #5 clk_i = ~clk_i;

  ascon_fsm #(.AD_CNT_W(4), .PT_CNT_W(4)) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .ad_blocks_i        (ad_blocks_i),
    .pt_blocks_i        (pt_blocks_i),
    .data_valid_i       (data_valid_i),
`ifdef ASCON_FSM_ABORT_EN
    .abort_i            (abort_i),
`endif
    .data_req_o         (data_req_o),
    .select_o           (select_o),
    .round_o            (round_o),
    .en_state_o         (en_state_o),
    .en_xor_data_o      (en_xor_data_o),
    .en_xor_key_begin_o (en_xor_key_begin_o),
    .en_xor_key_end_o   (en_xor_key_end_o),
    .en_xor_lsb_o       (en_xor_lsb_o),
    .en_cipher_o        (en_cipher_o),
    .en_tag_o           (en_tag_o),
    .cipher_valid_o     (cipher_valid_o),
    .tag_valid_o        (tag_valid_o),
    .done_o             (done_o)
  );

  // Bit layout: req sel round[3:0] st xd kb ke lsb ci tag cv tv done
  logic [15:0] dut_v;
  assign dut_v = {data_req_o, select_o, round_o, en_state_o, en_xor_data_o, en_xor_key_begin_o,
                  en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o, cipher_valid_o,
                  tag_valid_o, done_o};

  localparam logic [15:0] M_ALL   = 16'hFFFF;
  localparam logic [15:0] M_NOSEL = 16'hBFFF;
  localparam logic [15:0] M_DONE  = 16'h83FF;

  logic [15:0] exp_q[$];
  logic [15:0] msk_q[$];
  bit          dv_q[$];
  int          cur = 0;
  bit          active = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dut_done_cyc = -1;
  int          dut_cv_q[$];

  bit          xchk_vld = 1'b0;
  bit          xchk_use_dut = 1'b0;
  logic [15:0] xchk_got, xchk_want, xchk_mask;
  string       xchk_name;
  logic [15:0] chk_g;

  function automatic logic [15:0] mk(bit req, bit sel, int rnd, bit st, bit xd, bit kb, bit ke,
                                     bit lsb, bit ci, bit tg, bit tv, bit dn);
    logic [3:0] r4;
    r4 = 4'(rnd);
    return {req, sel, r4, st, xd, kb, ke, lsb, ci, tg, 1'b0, tv, dn};
  endfunction

  task automatic push(logic [15:0] v, logic [15:0] m, bit d);
    exp_q.push_back(v);
    msk_q.push_back(m);
    dv_q.push_back(d);
  endtask

  // A wait phase lasts one cycle plus any stall; the round index stays at the previous phase's last round.
  task automatic push_wait(int w, int sw, int sl);
    int n;
    n = 1 + ((w == sw) ? sl : 0);
    for (int j = 0; j < n; j++)
      push(mk(1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_NOSEL, j == n - 1);
  endtask

  task automatic build(int ad, int pt, int sw, int sl);
    int ptn;
    int w;
    exp_q.delete(); msk_q.delete(); dv_q.delete();
    push(16'h0000, 16'h0000, 1'b1);
    ptn = (pt == 0) ? 1 : pt;
    w = 0;
    for (int r = 0; r < 12; r++)
      push(mk(0, r != 0, r, 1, 0, 0, r == 11, (r == 11) && (ad == 0), 0, 0, 0, 0), M_ALL, 1'b1);
    for (int b = 0; b < ad; b++) begin
      push_wait(w, sw, sl); w++;
      for (int r = 6; r < 12; r++)
        push(mk(0, 1, r, 1, r == 6, 0, 0, (r == 11) && (b == ad - 1), 0, 0, 0, 0), M_ALL, 1'b1);
    end
    for (int b = 0; b < ptn - 1; b++) begin
      push_wait(w, sw, sl); w++;
      for (int r = 6; r < 12; r++)
        push(mk(0, 1, r, 1, r == 6, 0, 0, 0, r == 6, 0, 0, 0), M_ALL, 1'b1);
    end
    push_wait(w, sw, sl);
    for (int r = 0; r < 12; r++)
      push(mk(0, 1, r, 1, r == 0, r == 0, r == 11, 0, r == 0, r == 11, 0, 0), M_ALL, 1'b1);
    for (int d = 0; d < 4; d++)
      push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), M_DONE, 1'b1);
    for (int i = 1; i < exp_q.size(); i++)
      if (exp_q[i-1][4]) exp_q[i] = exp_q[i] | 16'h0004;
  endtask

  function automatic int model_done();
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][0]) return i;
    return -1;
  endfunction

  function automatic int model_cv(int nth);
    int seen;
    seen = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][2]) begin
        if (seen == nth) return i;
        seen++;
      end
    return -1;
  endfunction

  task automatic req_check(string name, bit use_dut, logic [15:0] got, logic [15:0] want,
                           logic [15:0] mask);
    xchk_name = name; xchk_use_dut = use_dut; xchk_got = got; xchk_want = want;
    xchk_mask = mask; xchk_vld = 1'b1;
    @(negedge clk_i); #1;
    xchk_vld = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (active) begin
      if (cur == 1) begin
        dut_done_cyc = -1;
        dut_cv_q.delete();
      end
      n_cmp++;
      if ((dut_v & msk_q[cur]) !== (exp_q[cur] & msk_q[cur])) begin
        n_bad++;
        $display("FAIL trace cyc=%0d got=%h want=%h mask=%h", cur, dut_v, exp_q[cur], msk_q[cur]);
      end
      if (done_o && dut_done_cyc < 0) dut_done_cyc = cur;
      if (cipher_valid_o) dut_cv_q.push_back(cur);
    end
    if (xchk_vld) begin
      chk_g = xchk_use_dut ? dut_v : xchk_got;
      n_cmp++;
      if ((chk_g & xchk_mask) !== (xchk_want & xchk_mask)) begin
        n_bad++;
        $display("FAIL %s got=%h want=%h", xchk_name, chk_g, xchk_want);
      end
    end
  end

  // Starts a run from IDLE or DONE; stops early (still in cycle stop_at) when stop_at > 0.
  task automatic run(int ad, int pt, int sw, int sl, int start_at, int stop_at);
    build(ad, pt, sw, sl);
    @(negedge clk_i);
    ad_blocks_i = 4'(ad); pt_blocks_i = 4'(pt); start_i = 1'b1; data_valid_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k < exp_q.size(); k++) begin
      cur = k; active = 1'b1;
      data_valid_i = dv_q[k];
      start_i = (k == start_at);
      if (k == stop_at) break;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    if (stop_at == 0) active = 1'b0;
  endtask

  task automatic check_done(string name, int want);
    req_check({name, "_model_done"}, 0, 16'(model_done()), 16'(want), M_ALL);
    req_check({name, "_dut_done"}, 0, 16'(dut_done_cyc), 16'(want), M_ALL);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    req_check("reset_state", 1, 16'h0, 16'h0000, M_ALL);
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    // Nominal ad=1 pt=4, with a stray start pulse during AD.
    run(1, 4, -1, 0, 15, 0);
    check_done("nominal", 54);
    req_check("cv_count", 0, 16'(dut_cv_q.size()), 16'd4, M_ALL);
    req_check("cv_pulse0", 0, 16'(dut_cv_q[0]), 16'd22, M_ALL);
    req_check("cv_pulse1", 0, 16'(dut_cv_q[1]), 16'd29, M_ALL);
    req_check("cv_pulse2", 0, 16'(dut_cv_q[2]), 16'd36, M_ALL);
    req_check("cv_pulse3", 0, 16'(dut_cv_q[3]), 16'd43, M_ALL);
    req_check("model_cv0", 0, 16'(model_cv(0)), 16'd22, M_ALL);
    req_check("model_cv3", 0, 16'(model_cv(3)), 16'd43, M_ALL);

    // Restart from DONE, then reset in FINAL round 5.
    run(1, 4, -1, 0, 0, 47);
    @(negedge clk_i); #1;
    active = 1'b0;
    reset_i = 1'b1;
    req_check("reset_mid_final", 1, 16'h0, 16'h0000, M_ALL);
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    run(1, 4, -1, 0, 0, 0);
    check_done("after_reset", 54);

    // Five-cycle stall in the second WAIT_PT.
    run(1, 4, 2, 5, 0, 0);
    check_done("stall", 59);

    run(0, 1, -1, 0, 0, 0);
    check_done("ad0_pt1", 26);

    run(0, 0, -1, 0, 0, 0);
    check_done("ad0_pt0", 26);

    run(2, 2, -1, 0, 0, 0);
    check_done("ad2_pt2", 47);

`ifdef ASCON_FSM_ABORT_EN
    run(1, 4, -1, 0, 0, 23);
    abort_i = 1'b1;
    @(negedge clk_i); #1;
    active = 1'b0;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    req_check("abort_idle", 1, 16'h0, 16'h0000, M_ALL);
    repeat (3) req_check("abort_no_done", 1, 16'h0, 16'h0000, M_ALL);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
